// File: rtl/dcu_wb_biu.sv
// rtl/dcu_wb_biu.sv - DCU writeback/NC store sequencer onto the BIU store port
// One request/grant/ack transaction per word, with an ack timeout.
module dcu_wb_biu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_req,
  input  logic        nc_write_cyc,
  input  logic [3:0]  wb_sel,
  input  logic        miss_idle,
  input  logic [31:0] wb_data,
  input  logic [27:0] wb_line_addr,
  input  logic [31:0] nc_addr,
  input  logic [1:0]  nc_size,
  input  logic        mem_gnt,
  input  logic [1:0]  mem_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [1:0]  mem_type,
  output logic [1:0]  mem_size,
  output logic        mem_last,
  output logic        normal_ack,
  output logic        error_ack,
  output logic        biu_busy
);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, DONE} state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [1:0]  mem_type_q, mem_type_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        mem_last_q, mem_last_d;
  logic        normal_ack_q, normal_ack_d;
  logic        error_ack_q, error_ack_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx;
  logic        issue;

  // wb_sel is one-hot, so an OR-encode yields the word index
  assign idx   = {wb_sel[3] | wb_sel[2], wb_sel[3] | wb_sel[1]};
  assign issue = wb_req & (nc_write_cyc | ~wb_sel[0] | miss_idle);

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_type_d   = mem_type_q;
    mem_size_d   = mem_size_q;
    mem_last_d   = mem_last_q;
    normal_ack_d = 1'b0;
    error_ack_d  = 1'b0;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = nc_write_cyc ? nc_addr : {wb_line_addr, idx, 2'b00};
          mem_data_d = wb_data;
          mem_type_d = nc_write_cyc ? 2'b01 : 2'b10;
          mem_size_d = nc_write_cyc ? nc_size : 2'b10;
          mem_last_d = ~nc_write_cyc & wb_sel[3];
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          cnt_d     = 8'd0;
          if (mem_ack != 2'b00) begin
            state_d      = DONE;
            normal_ack_d = (mem_ack == 2'b01);
            error_ack_d  = (mem_ack != 2'b01);
          end else begin
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + 8'd1;
        // A real ack takes priority over the timeout on the same cycle
        if (mem_ack != 2'b00) begin
          state_d      = DONE;
          normal_ack_d = (mem_ack == 2'b01);
          error_ack_d  = (mem_ack != 2'b01);
        end else if (cnt_d == TIMEOUT_CNT) begin
          state_d     = DONE;
          error_ack_d = 1'b1;
        end
      end
      DONE: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_data_q   <= 32'd0;
      mem_type_q   <= 2'b00;
      mem_size_q   <= 2'b00;
      mem_last_q   <= 1'b0;
      normal_ack_q <= 1'b0;
      error_ack_q  <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_type_q   <= mem_type_d;
      mem_size_q   <= mem_size_d;
      mem_last_q   <= mem_last_d;
      normal_ack_q <= normal_ack_d;
      error_ack_q  <= error_ack_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_type   = mem_type_q;
  assign mem_size   = mem_size_q;
  assign mem_last   = mem_last_q;
  assign normal_ack = normal_ack_q;
  assign error_ack  = error_ack_q;
  assign biu_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_dcu_wb_biu.sv
// tb/tb_dcu_wb_biu.sv - self-checking bench for dcu_wb_biu
// Transaction-level reference model plus directed scenarios with literal expectations.
module tb_dcu_wb_biu;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_req, nc_write_cyc, miss_idle;
  logic [3:0]  wb_sel;
  logic [31:0] wb_data, nc_addr;
  logic [27:0] wb_line_addr;
  logic [1:0]  nc_size;
  logic        auto_gnt, man_gnt;
  logic [1:0]  auto_ack, man_ack;
  wire         mem_gnt = auto_gnt | man_gnt;
  wire  [1:0]  mem_ack = auto_ack | man_ack;
  logic        mem_req, mem_last, normal_ack, error_ack, biu_busy;
  logic [31:0] mem_addr, mem_data;
  logic [1:0]  mem_type, mem_size;

  dcu_wb_biu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wb_req(wb_req), .nc_write_cyc(nc_write_cyc),
    .wb_sel(wb_sel), .miss_idle(miss_idle), .wb_data(wb_data),
    .wb_line_addr(wb_line_addr), .nc_addr(nc_addr), .nc_size(nc_size),
    .mem_gnt(mem_gnt), .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_type(mem_type), .mem_size(mem_size),
    .mem_last(mem_last), .normal_ack(normal_ack), .error_ack(error_ack),
    .biu_busy(biu_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks one outstanding word at transaction level
  bit          e_req = 0, e_busy = 0, e_nack = 0, e_eack = 0, e_last = 0;
  logic [31:0] e_addr = 0, e_data = 0;
  logic [1:0]  e_type = 0, e_size = 0;
  int          since_gnt = 0;

  always @(posedge clk) begin
    logic [1:0] code;
    int         w;
    cyc++;
    code = 2'b00;
    if (reset) begin
      e_req = 0; e_busy = 0; e_nack = 0; e_eack = 0;
    end else if (e_nack || e_eack) begin
      e_nack = 0; e_eack = 0; e_busy = 0;
    end else if (!e_busy) begin
      if (wb_req && (nc_write_cyc || !wb_sel[0] || miss_idle)) begin
        w = 0;
        for (int i = 0; i < 4; i++) if (wb_sel[i]) w = i;
        e_busy = 1; e_req = 1;
        e_addr = nc_write_cyc ? nc_addr : ({wb_line_addr, 4'h0} + 32'(w * 4));
        e_data = wb_data;
        e_type = nc_write_cyc ? 2'b01 : 2'b10;
        e_size = nc_write_cyc ? nc_size : 2'b10;
        e_last = !nc_write_cyc && (w == 3);
      end
    end else if (e_req) begin
      if (mem_gnt) begin
        e_req = 0;
        since_gnt = 0;
        code = mem_ack;
      end
    end else begin
      since_gnt++;
      if (mem_ack != 2'b00) code = mem_ack;
      else if (since_gnt == TIMEOUT) code = 2'b10;
    end
    if (code != 2'b00) begin
      e_nack = (code == 2'b01);
      e_eack = (code != 2'b01);
    end
  end

  // Event log for the directed literal checks
  int          ack_cyc[$];
  bit          ack_err[$];
  int          req_cyc[$];
  logic [31:0] req_addr[$];
  bit          req_last[$];
  logic [1:0]  req_type[$], req_size[$];
  logic        prev_req = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("mem_req", 32'(mem_req), 32'(e_req));
      check("biu_busy", 32'(biu_busy), 32'(e_busy));
      check("normal_ack", 32'(normal_ack), 32'(e_nack));
      check("error_ack", 32'(error_ack), 32'(e_eack));
      if (e_req) begin
        check("mem_addr", mem_addr, e_addr);
        check("mem_data", mem_data, e_data);
        check("mem_type", 32'(mem_type), 32'(e_type));
        check("mem_size", 32'(mem_size), 32'(e_size));
        check("mem_last", 32'(mem_last), 32'(e_last));
      end
      if (mem_req && !prev_req) begin
        req_cyc.push_back(cyc);
        req_addr.push_back(mem_addr);
        req_last.push_back(mem_last);
        req_type.push_back(mem_type);
        req_size.push_back(mem_size);
      end
      if (normal_ack || error_ack) begin
        ack_cyc.push_back(cyc);
        ack_err.push_back(error_ack);
      end
    end
    prev_req = mem_req;
  end

  // BIU responder: grant after cfg_gnt_dly req cycles, ack cfg_ack_dly cycles after grant
  int         cfg_gnt_dly = 0, cfg_ack_dly = 0;
  logic [1:0] cfg_code = 2'b01;
  int         req_cnt = 0, gnt_cnt = 0, gnt_cyc = 0;
  bit         granted = 0;

  initial begin
    auto_gnt = 0; auto_ack = 2'b00;
    forever begin
      @(posedge clk); #1;
      auto_gnt = 0; auto_ack = 2'b00;
      if (!biu_busy || normal_ack || error_ack) begin
        granted = 0; req_cnt = 0;
      end else if (mem_req && !granted) begin
        if (req_cnt == cfg_gnt_dly) begin
          auto_gnt = 1; granted = 1; gnt_cnt = 0; gnt_cyc = cyc;
          if (cfg_ack_dly == 0) auto_ack = cfg_code;
        end
        req_cnt++;
      end else if (granted) begin
        gnt_cnt++;
        if (gnt_cnt == cfg_ack_dly) auto_ack = cfg_code;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int b = 0;
    while (ack_cyc.size() < n && b < budget) begin tick(1); b++; end
    check("pulse_wait", 32'(ack_cyc.size()), 32'(n));
  endtask

  task automatic clear_logs();
    ack_cyc.delete(); ack_err.delete(); req_cyc.delete(); req_addr.delete();
    req_last.delete(); req_type.delete(); req_size.delete();
  endtask

  task automatic nc_word(input logic [31:0] a, input int gd, input int ad, input logic [1:0] c);
    cfg_gnt_dly = gd; cfg_ack_dly = ad; cfg_code = c;
    nc_write_cyc = 1; nc_addr = a; nc_size = 2'b10; wb_data = ~a; wb_sel = 4'b0000;
    wb_req = 1;
  endtask

  initial begin
    int t0;
    reset = 1; wb_req = 0; nc_write_cyc = 0; miss_idle = 0; wb_sel = 0;
    wb_data = 0; nc_addr = 0; nc_size = 0; wb_line_addr = 0;
    man_gnt = 0; man_ack = 2'b00;
    tick(1);
    chk_on = 1;
    tick(1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(biu_busy), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_acks", 32'({normal_ack, error_ack, mem_last}), 32'd0);
    reset = 0;
    tick(2);

    // NC byte store: gnt in cycle 2, ack 01 in cycle 4, normal_ack in cycle 5
    clear_logs();
    cfg_gnt_dly = 1; cfg_ack_dly = 2; cfg_code = 2'b01;
    nc_write_cyc = 1; nc_addr = 32'h8000_0013; nc_size = 2'b00; wb_data = 32'hA5A5_0013;
    wb_req = 1; t0 = cyc;
    wait_pulses(1, 50);
    wb_req = 0;
    check("nc_req_cycle", 32'(req_cyc[0] - t0), 32'd1);
    check("nc_gnt_cycle", 32'(gnt_cyc - t0), 32'd2);
    check("nc_ack_cycle", 32'(ack_cyc[0] - t0), 32'd5);
    check("nc_ack_kind", 32'(ack_err[0]), 32'd0);
    check("nc_addr", req_addr[0], 32'h8000_0013);
    check("nc_type", 32'(req_type[0]), 32'd1);
    check("nc_size", 32'(req_size[0]), 32'd0);
    tick(3);
    check("nc_single_ack", 32'(ack_cyc.size()), 32'd1);

    // 4-word writeback, immediate gnt+ack
    clear_logs();
    cfg_gnt_dly = 0; cfg_ack_dly = 0; cfg_code = 2'b01;
    nc_write_cyc = 0; miss_idle = 1; wb_line_addr = 28'h123_4567; wb_req = 1;
    for (int w = 0; w < 4; w++) begin
      wb_sel = 4'b0001 << w;
      wb_data = 32'hD000_0000 + 32'(w);
      wait_pulses(w + 1, 50);
    end
    wb_req = 0;
    tick(3);
    check("wb_ack_count", 32'(ack_cyc.size()), 32'd4);
    check("wb_req_count", 32'(req_cyc.size()), 32'd4);
    for (int w = 0; w < 4 && w < req_cyc.size(); w++) begin
      check("wb_addr", req_addr[w], 32'h1234_5670 + 32'(4 * w));
      check("wb_last", 32'(req_last[w]), (w == 3) ? 32'd1 : 32'd0);
      check("wb_size", 32'(req_size[w]), 32'd2);
      check("wb_type", 32'(req_type[w]), 32'd2);
    end
    if (ack_cyc.size() == 4) check("wb_3cyc_per_word", 32'(ack_cyc[3] - ack_cyc[0]), 32'd9);

    // First-word gating on miss_idle; later words are not gated
    clear_logs();
    miss_idle = 0; wb_sel = 4'b0001; wb_data = 32'h1111_0000; wb_req = 1;
    tick(10);
    check("gate_no_req", 32'(req_cyc.size()), 32'd0);
    check("gate_not_busy", 32'(biu_busy), 32'd0);
    miss_idle = 1; t0 = cyc;
    wait_pulses(1, 20);
    check("gate_release", 32'(req_cyc[0] - t0), 32'd1);
    miss_idle = 0; wb_sel = 4'b0010; t0 = cyc;
    wait_pulses(2, 20);
    wb_req = 0;
    check("gate_word1_req", 32'(req_cyc[1] - t0), 32'd1);
    check("gate_word1_addr", req_addr[1], 32'h1234_5674);
    tick(2);

    // Timeout: no ack -> error_ack TIMEOUT+1 cycles after gnt
    clear_logs();
    nc_word(32'h4000_0100, 0, -1, 2'b01);
    wait_pulses(1, 400);
    wb_req = 0;
    check("to_kind", 32'(ack_err[0]), 32'd1);
    check("to_latency", 32'(ack_cyc[0] - gnt_cyc), 32'(TIMEOUT + 1));
    check("to_idle", 32'(biu_busy), 32'd0);
    tick(2);

    // Ack on the timeout cycle wins
    clear_logs();
    nc_word(32'h4000_0200, 0, TIMEOUT, 2'b01);
    wait_pulses(1, 400);
    wb_req = 0;
    check("to_edge_kind", 32'(ack_err[0]), 32'd0);
    check("to_edge_latency", 32'(ack_cyc[0] - gnt_cyc), 32'(TIMEOUT + 1));
    tick(2);

    // Error response codes 11 (same-cycle) and 10 (delayed)
    clear_logs();
    nc_word(32'h4000_0300, 0, 0, 2'b11); t0 = cyc;
    wait_pulses(1, 20);
    wb_req = 0;
    check("ack11_kind", 32'(ack_err[0]), 32'd1);
    check("ack11_cycle", 32'(ack_cyc[0] - t0), 32'd2);
    tick(2);
    nc_word(32'h4000_0304, 2, 3, 2'b10);
    wait_pulses(2, 20);
    wb_req = 0;
    check("ack10_kind", 32'(ack_err[1]), 32'd1);
    tick(2);

    // Reset in WAIT_ACK: outputs drop, later ack ignored
    clear_logs();
    nc_word(32'h4000_0400, 0, -1, 2'b01);
    tick(4);
    check("pre_rst_wait", 32'({biu_busy, mem_req}), 32'b10);
    reset = 1; wb_req = 0;
    tick(1);
    reset = 0;
    check("rst_wait_req", 32'(mem_req), 32'd0);
    check("rst_wait_busy", 32'(biu_busy), 32'd0);
    check("rst_wait_addr", mem_addr, 32'd0);
    man_gnt = 1; man_ack = 2'b01;
    tick(3);
    man_gnt = 0; man_ack = 2'b00;
    tick(2);
    check("rst_no_pulse", 32'(ack_cyc.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
